// File: rtl/loopback_ctrl_pkg.sv
// Shared types and default widths for the loopback transfer sequencer.
package loopback_ctrl_pkg;

    typedef enum logic [1:0] {
        LB_IDLE,
        LB_RUN,
        LB_DONE
    } lb_state_t;

    localparam int LB_ADDR_W = 42;
    localparam int LB_DATA_W = 512;
    localparam int LB_DEPTH  = 8;
    localparam int LB_CNT_W  = 32;

endpackage

// File: rtl/loopback_ctrl.sv
// Loopback copy sequencer: credit-limited reads into the staging FIFO,
// in-order writes out of it, done once every write has completed.
module loopback_ctrl
    import loopback_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = LB_ADDR_W,
    parameter int DATA_WIDTH = LB_DATA_W,
    parameter int FIFO_DEPTH = LB_DEPTH,
    parameter int CNT_WIDTH  = LB_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       src_addr,
    input  logic [ADDR_WIDTH-1:0]       dst_addr,
    input  logic [CNT_WIDTH-1:0]        num_lines,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic                        rd_req_valid,
    output logic [ADDR_WIDTH-1:0]       rd_req_addr,
    input  logic                        rd_almost_full,
    input  logic                        rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0]       rd_rsp_data,
    output logic                        wr_req_valid,
    output logic [ADDR_WIDTH-1:0]       wr_req_addr,
    output logic [DATA_WIDTH-1:0]       wr_req_data,
    input  logic                        wr_almost_full,
    input  logic                        wr_rsp_valid,
    output logic [DATA_WIDTH-1:0]       fifo_enq_data,
    output logic                        fifo_enq_en,
    input  logic                        fifo_full,
    input  logic [DATA_WIDTH-1:0]       fifo_deq_data,
    output logic                        fifo_deq_en,
    input  logic                        fifo_empty,
    input  logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CRW = $clog2(FIFO_DEPTH) + 2;

    lb_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  rd_req_cnt_q, rd_req_cnt_d;
    logic [CNT_WIDTH-1:0]  rd_rsp_cnt_q, rd_rsp_cnt_d;
    logic [CNT_WIDTH-1:0]  wr_req_cnt_q, wr_req_cnt_d;
    logic [CNT_WIDTH-1:0]  wr_rsp_cnt_q, wr_rsp_cnt_d;
    logic                  rd_req_valid_q, rd_req_valid_d;
    logic [ADDR_WIDTH-1:0] rd_req_addr_q, rd_req_addr_d;
    logic                  wr_req_valid_q, wr_req_valid_d;
    logic [ADDR_WIDTH-1:0] wr_req_addr_q, wr_req_addr_d;
    logic [DATA_WIDTH-1:0] wr_req_data_q, wr_req_data_d;
    logic                  error_q, error_d;
    logic                  nonempty_prev_q, nonempty_prev_d;
    logic                  pop_prev_q, pop_prev_d;

    logic                  run;
    logic                  start_ok;
    logic [CNT_WIDTH-1:0]  outstanding;
    logic [CRW-1:0]        credit;
    logic                  rd_issue;
    logic                  rsp_take;
    logic                  head_ok;
    logic                  pop;
    logic                  wr_rsp_take;

    assign run         = (state_q == LB_RUN);
    assign start_ok    = start && !run;
    assign outstanding = rd_req_cnt_q - rd_rsp_cnt_q;
    // Lines already queued plus reads still in flight must fit the FIFO.
    assign credit      = CRW'(fifo_count) + CRW'(outstanding);
    assign rd_issue    = run && (rd_req_cnt_q < num_q) && !rd_almost_full
                         && (credit < CRW'(FIFO_DEPTH - 1));
    assign rsp_take    = run && rd_rsp_valid;
    // The FIFO head register lags its pointer, so skip a cycle after a pop.
    assign head_ok     = !fifo_empty && nonempty_prev_q && !pop_prev_q;
    assign pop         = run && !wr_almost_full && head_ok;
    assign wr_rsp_take = run && wr_rsp_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LB_IDLE, LB_DONE: begin
                if (start) state_d = (num_lines != '0) ? LB_RUN : LB_DONE;
            end
            LB_RUN: begin
                if (wr_rsp_cnt_q == num_q) state_d = LB_DONE;
            end
            default: state_d = LB_IDLE;
        endcase
    end

    always_comb begin
        src_d           = src_q;
        dst_d           = dst_q;
        num_d           = num_q;
        rd_req_cnt_d    = rd_req_cnt_q + CNT_WIDTH'(rd_issue);
        rd_rsp_cnt_d    = rd_rsp_cnt_q + CNT_WIDTH'(rsp_take);
        wr_req_cnt_d    = wr_req_cnt_q + CNT_WIDTH'(pop);
        wr_rsp_cnt_d    = wr_rsp_cnt_q + CNT_WIDTH'(wr_rsp_take);
        rd_req_valid_d  = rd_issue;
        rd_req_addr_d   = rd_req_addr_q;
        wr_req_valid_d  = pop;
        wr_req_addr_d   = wr_req_addr_q;
        wr_req_data_d   = wr_req_data_q;
        error_d         = error_q | (rsp_take && fifo_full);
        nonempty_prev_d = !fifo_empty;
        pop_prev_d      = pop;
        if (rd_issue) rd_req_addr_d = src_q + ADDR_WIDTH'(rd_req_cnt_q);
        if (pop) begin
            wr_req_addr_d = dst_q + ADDR_WIDTH'(wr_req_cnt_q);
            wr_req_data_d = fifo_deq_data;
        end
        if (start_ok) begin
            src_d        = src_addr;
            dst_d        = dst_addr;
            num_d        = num_lines;
            rd_req_cnt_d = '0;
            rd_rsp_cnt_d = '0;
            wr_req_cnt_d = '0;
            wr_rsp_cnt_d = '0;
            error_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LB_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q           <= '0;
            dst_q           <= '0;
            num_q           <= '0;
            rd_req_cnt_q    <= '0;
            rd_rsp_cnt_q    <= '0;
            wr_req_cnt_q    <= '0;
            wr_rsp_cnt_q    <= '0;
            rd_req_valid_q  <= 1'b0;
            rd_req_addr_q   <= '0;
            wr_req_valid_q  <= 1'b0;
            wr_req_addr_q   <= '0;
            wr_req_data_q   <= '0;
            error_q         <= 1'b0;
            nonempty_prev_q <= 1'b0;
            pop_prev_q      <= 1'b0;
        end else begin
            src_q           <= src_d;
            dst_q           <= dst_d;
            num_q           <= num_d;
            rd_req_cnt_q    <= rd_req_cnt_d;
            rd_rsp_cnt_q    <= rd_rsp_cnt_d;
            wr_req_cnt_q    <= wr_req_cnt_d;
            wr_rsp_cnt_q    <= wr_rsp_cnt_d;
            rd_req_valid_q  <= rd_req_valid_d;
            rd_req_addr_q   <= rd_req_addr_d;
            wr_req_valid_q  <= wr_req_valid_d;
            wr_req_addr_q   <= wr_req_addr_d;
            wr_req_data_q   <= wr_req_data_d;
            error_q         <= error_d;
            nonempty_prev_q <= nonempty_prev_d;
            pop_prev_q      <= pop_prev_d;
        end
    end

    assign busy          = run;
    assign done          = (state_q == LB_DONE);
    assign error         = error_q;
    assign rd_req_valid  = rd_req_valid_q;
    assign rd_req_addr   = rd_req_addr_q;
    assign wr_req_valid  = wr_req_valid_q;
    assign wr_req_addr   = wr_req_addr_q;
    assign wr_req_data   = wr_req_data_q;
    assign fifo_enq_en   = rsp_take;
    assign fifo_enq_data = rd_rsp_data;
    assign fifo_deq_en   = pop;

endmodule

// File: tb/tb_loopback_ctrl.sv
// Scoreboard bench for loopback_ctrl with memory, write-channel and
// staging-FIFO models driven from randomized timing.
module tb_loopback_ctrl;

    localparam int AW = 42;
    localparam int DW = 512;
    localparam int FD = 8;
    localparam int NW = 32;
    localparam int CW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr, dst_addr;
    logic [NW-1:0] num_lines;
    logic          busy, done, error;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_addr;
    logic          rd_almost_full;
    logic          rd_rsp_valid;
    logic [DW-1:0] rd_rsp_data;
    logic          wr_req_valid;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic          wr_almost_full;
    logic          wr_rsp_valid;
    logic [DW-1:0] fifo_enq_data;
    logic          fifo_enq_en;
    logic          fifo_full;
    logic [DW-1:0] fifo_deq_data;
    logic          fifo_deq_en;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    loopback_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .num_lines(num_lines),
        .busy(busy), .done(done), .error(error),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
        .rd_almost_full(rd_almost_full),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr),
        .wr_req_data(wr_req_data), .wr_almost_full(wr_almost_full),
        .wr_rsp_valid(wr_rsp_valid),
        .fifo_enq_data(fifo_enq_data), .fifo_enq_en(fifo_enq_en),
        .fifo_full(fifo_full), .fifo_deq_data(fifo_deq_data),
        .fifo_deq_en(fifo_deq_en), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    int     rd_seen = 0, wr_seen = 0, max_occ = 0;
    int     rd_delay = 2;
    bit     rd_af_rand = 0, wr_af_rand = 0, wr_af_hold = 0;
    bit     inject = 0, chk_credit = 1;

    typedef struct { logic [AW-1:0] a; longint t; } rd_ent_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_ent_t;
    rd_ent_t       rdq[$];
    longint        wq[$];
    logic [AW-1:0] exp_rd[$];
    wr_ent_t       exp_wr[$];

    // Memory contents as a pure function of the line address.
    function automatic logic [DW-1:0] line_of(logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++)
            d[k*32 +: 32] = a[31:0] ^ (32'h9E37_79B9 * 32'(k + 1))
                            ^ {22'd0, a[AW-1:32]};
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd_almost_full <= rd_af_rand && ($urandom_range(0, 3) == 0);
        wr_almost_full <= wr_af_hold
                          || (wr_af_rand && ($urandom_range(0, 3) == 0));
    end

    // Host read channel: in-order responses after a minimum delay.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rdq.delete();
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
        end else begin
            rd_rsp_valid <= 1'b0;
            if (inject) begin
                rd_rsp_valid <= 1'b1;
                rd_rsp_data  <= {16{32'hDEAD_BEEF}};
            end else if (rdq.size() > 0 && rdq[0].t <= cyc
                         && $urandom_range(0, 3) != 0) begin
                rd_rsp_valid <= 1'b1;
                rd_rsp_data  <= line_of(rdq[0].a);
                void'(rdq.pop_front());
            end
            if (rd_req_valid) rdq.push_back('{rd_req_addr, cyc + rd_delay});
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wq.delete();
            wr_rsp_valid <= 1'b0;
        end else begin
            wr_rsp_valid <= 1'b0;
            if (wq.size() > 0 && wq[0] <= cyc) begin
                wr_rsp_valid <= 1'b1;
                void'(wq.pop_front());
            end
            if (wr_req_valid) wq.push_back(cyc + $urandom_range(1, 4));
        end
    end

    // Staging FIFO: FD-1 usable entries, head data registered.
    logic [DW-1:0] fmem [FD];
    logic [2:0]    wp, rp;
    logic [CW-1:0] fcnt;
    assign fifo_count = fcnt;
    assign fifo_full  = (fcnt == CW'(FD - 1));
    assign fifo_empty = (fcnt == '0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0; rp <= '0; fcnt <= '0; fifo_deq_data <= '0;
        end else begin
            logic e, d;
            e = fifo_enq_en && !fifo_full;
            d = fifo_deq_en && !fifo_empty;
            fifo_deq_data <= fmem[rp];
            if (e) begin fmem[wp] <= fifo_enq_data; wp <= wp + 3'd1; end
            if (d) rp <= rp + 3'd1;
            fcnt <= fcnt + CW'(e) - CW'(d);
        end
    end

    // Monitor: pops expectations whenever the DUT issues a request.
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_req_valid) begin
                rd_seen++;
                vectors++;
                if (exp_rd.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_unexpected: addr %0h, none expected",
                             rd_req_addr);
                end else begin
                    logic [AW-1:0] ea;
                    ea = exp_rd.pop_front();
                    if (rd_req_addr !== ea) begin
                        miscompares++;
                        $display("FAIL rd_addr: got %0h expected %0h",
                                 rd_req_addr, ea);
                    end
                end
            end
            if (wr_req_valid) begin
                wr_seen++;
                vectors++;
                if (exp_wr.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected: addr %0h, none expected",
                             wr_req_addr);
                end else begin
                    wr_ent_t ew;
                    ew = exp_wr.pop_front();
                    if (wr_req_addr !== ew.a || wr_req_data !== ew.d) begin
                        miscompares++;
                        $display("FAIL wr_req: got %0h/%0h expected %0h/%0h",
                                 wr_req_addr, wr_req_data[63:0],
                                 ew.a, ew.d[63:0]);
                    end
                end
            end
            if (chk_credit && busy) begin
                int occ;
                occ = int'(fcnt) + rdq.size() + int'(rd_rsp_valid)
                      + int'(rd_req_valid);
                if (occ > max_occ) max_occ = occ;
                if (occ > FD - 1) begin
                    miscompares++;
                    $display("FAIL credit: occupancy %0d exceeds %0d",
                             occ, FD - 1);
                end
            end
            if (fifo_deq_en && fifo_empty) begin
                miscompares++;
                $display("FAIL deq_empty: pop %0b while empty", fifo_deq_en);
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_xfer(logic [AW-1:0] s, logic [AW-1:0] d, int n);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(s + AW'(i));
            exp_wr.push_back('{d + AW'(i), line_of(s + AW'(i))});
        end
        @(negedge clk);
        src_addr = s; dst_addr = d; num_lines = NW'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) return;
            @(negedge clk);
        end
        miscompares++;
        $display("FAIL done_timeout: done %0b after %0d cycles", done, budget);
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_rdv"}, 64'(rd_req_valid), 64'd0);
        chk({tag, "_wrv"}, 64'(wr_req_valid), 64'd0);
        chk({tag, "_enq"}, 64'(fifo_enq_en), 64'd0);
        chk({tag, "_deq"}, 64'(fifo_deq_en), 64'd0);
        chk({tag, "_rda"}, 64'(rd_req_addr), 64'd0);
        chk({tag, "_wra"}, 64'(wr_req_addr), 64'd0);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return AW'({$urandom(), $urandom()});
    endfunction

    initial begin
        int r0, w0;
        reset = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; num_lines = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;

        start_xfer(42'h100, 42'h200, 1);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done(300);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_error", 64'(error), 64'd0);
        chk("t1_rd_count", 64'(rd_seen), 64'd1);
        chk("t1_wr_count", 64'(wr_seen), 64'd1);
        chk("t1_left", 64'(exp_wr.size()), 64'd0);

        r0 = rd_seen; w0 = wr_seen;
        start_xfer(rnd_addr(), rnd_addr(), 0);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_busy", 64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        chk("t2_no_rd", 64'(rd_seen), 64'(r0));
        chk("t2_no_wr", 64'(wr_seen), 64'(w0));

        rd_delay = 30; max_occ = 0;
        start_xfer(rnd_addr(), rnd_addr(), 20);
        wait_done(4000);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_max_occ", 64'(max_occ), 64'(FD - 1));
        chk("t3_error", 64'(error), 64'd0);
        chk("t3_left", 64'(exp_wr.size()), 64'd0);
        rd_delay = 2;

        wr_af_hold = 1; r0 = rd_seen;
        start_xfer(rnd_addr(), rnd_addr(), 16);
        repeat (50) @(negedge clk);
        chk("t4_fifo_count", 64'(fifo_count), 64'(FD - 1));
        chk("t4_reads", 64'(rd_seen - r0), 64'(FD - 1));
        chk("t4_error_hold", 64'(error), 64'd0);
        wr_af_hold = 0;
        wait_done(2000);
        chk("t4_error", 64'(error), 64'd0);
        chk("t4_left", 64'(exp_wr.size()), 64'd0);

        wr_af_hold = 1; chk_credit = 0;
        start_xfer(rnd_addr(), rnd_addr(), FD - 1);
        for (int i = 0; i < 200 && fifo_count != CW'(FD - 1); i++)
            @(negedge clk);
        chk("t5_full", 64'(fifo_full), 64'd1);
        chk("t5_error_pre", 64'(error), 64'd0);
        inject = 1;
        @(negedge clk);
        inject = 0;
        @(negedge clk);
        chk("t5_error_set", 64'(error), 64'd1);
        wr_af_hold = 0;
        wait_done(2000);
        chk("t5_error_sticky", 64'(error), 64'd1);
        chk("t5_left", 64'(exp_wr.size()), 64'd0);
        chk_credit = 1;
        start_xfer(rnd_addr(), rnd_addr(), 0);
        chk("t5_error_clr", 64'(error), 64'd0);
        chk("t5_done", 64'(done), 64'd1);

        start_xfer(rnd_addr(), rnd_addr(), 10);
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        exp_rd.delete();
        exp_wr.delete();
        @(negedge clk);
        chk_idle_outputs("midrst");
        reset = 1'b0;
        start_xfer(rnd_addr(), rnd_addr(), 5);
        wait_done(1000);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_left", 64'(exp_wr.size()), 64'd0);

        rd_af_rand = 1; wr_af_rand = 1;
        for (int it = 0; it < 4; it++) begin
            rd_delay = $urandom_range(1, 6);
            start_xfer(rnd_addr(), rnd_addr(), $urandom_range(1, 15));
            wait_done(4000);
            chk("rnd_done", 64'(done), 64'd1);
            chk("rnd_error", 64'(error), 64'd0);
            chk("rnd_left", 64'(exp_wr.size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
